// File: rtl/alarm_siren_ctrl.sv
// Timed siren sequencer behind the alarm decision logic: entry delay, bounded siren, latched memory until ack.
// All outputs come from registers, so input changes show one cycle later. Define ALARM_STROBE_EN to pulse the siren on each tick.
module alarm_siren_ctrl #(
    parameter int TICK_DIV   = 1,
    parameter int ENTRY_DLY  = 10,
    parameter int SIREN_TIME = 50,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trig,
    input  logic          armed,
    input  logic          ack,
    output logic          siren,
    output logic          memo,
    output logic [1:0]    state,
    output logic [CW-1:0] remain
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        SIREN = 2'b10,
        HOLD  = 2'b11
    } state_t;

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DLY_LOAD = CW'(ENTRY_DLY - 1);
    localparam logic [CW-1:0] SIR_LOAD = CW'(SIREN_TIME - 1);
`ifdef ALARM_STROBE_EN
    localparam logic          STROBE   = 1'b1;
`else
    localparam logic          STROBE   = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          siren_q, siren_d;
    logic          tick;

    assign tick = (pre_q == PRE_LAST);

    // Prescaler defaults to 0, so it is held in IDLE/HOLD and cleared on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = '0;
        siren_d = 1'b0;
        if (ack || !armed) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_d = DELAY;
                        cnt_d   = DLY_LOAD;
                    end
                end
                DELAY: begin
                    if (!tick) begin
                        pre_d = pre_q + PW'(1);
                    end else if (cnt_q == '0) begin
                        state_d = SIREN;
                        cnt_d   = SIR_LOAD;
                        siren_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SIREN: begin
                    siren_d = siren_q;
                    if (!tick) begin
                        pre_d = pre_q + PW'(1);
                    end else if (cnt_q == '0) begin
                        state_d = HOLD;
                        siren_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                        siren_d = siren_q ^ STROBE;
                    end
                end
                HOLD: begin
                    if (trig) begin
                        state_d = SIREN;
                        cnt_d   = SIR_LOAD;
                        siren_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            siren_q <= siren_d;
        end
    end

    assign siren  = siren_q;
    assign memo   = state_q[1];
    assign state  = state_q;
    assign remain = (state_q == DELAY || state_q == SIREN) ? cnt_q : '0;

endmodule

// File: doc/alarm_siren_ctrl.md
# alarm_siren_ctrl

Sequential alarm controller placed directly downstream of the home-alarm decision logic (S, W, M → A). It consumes that combinational alarm request and turns it into a timed siren sequence: entry delay, siren for a bounded time, then a latched "alarm memory" indication until acknowledged. All timing is counted in prescaled ticks, so one instance serves both simulation (tick = 1 cycle) and board use (tick = slow rate).

## Interface
- TICK_DIV, 1: clock cycles per tick, ≥1
- ENTRY_DLY, 10: entry-delay length in ticks, ≥1
- SIREN_TIME, 50: siren-on length in ticks, ≥1
- CW, 16: width of the tick counter and of `remain`; ENTRY_DLY and SIREN_TIME must fit in CW bits

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- trig  in  1  alarm request (the A output of the decision logic), level
- armed  in  1  system armed (same S signal the decision logic uses), level
- ack  in  1  user acknowledge/disarm, sampled each cycle, one-cycle pulse expected
- siren  out  1  siren drive
- memo  out  1  alarm-memory LED
- state  out  2  current state encoding
- remain  out  CW  ticks left in the current timed state, 0 otherwise

## Operation
- States: IDLE=00, DELAY=01, SIREN=10, HOLD=11.
- Priority each cycle: reset > ack > !armed > trig/timer.
- IDLE: armed & trig → DELAY, load counter ENTRY_DLY-1, restart prescaler.
- DELAY: ack or !armed → IDLE. Else on tick: counter==0 → SIREN (load SIREN_TIME-1, restart prescaler), otherwise decrement. trig ignored (already pending).
- SIREN: ack or !armed → IDLE. Else on tick: counter==0 → HOLD, otherwise decrement. trig ignored.
- HOLD: ack or !armed → IDLE. armed & trig → SIREN (reload SIREN_TIME-1, restart prescaler).
- Prescaler: counts 0..TICK_DIV-1; tick asserts on the cycle it equals TICK_DIV-1, then wraps to 0. It is held at 0 in IDLE/HOLD and cleared on every entry into DELAY or SIREN.
- siren = 1 only in SIREN (see Configuration). memo = 1 in SIREN and HOLD.
- remain = counter value in DELAY/SIREN, 0 in IDLE/HOLD.
- Counter arithmetic unsigned, CW bits, never decremented below 0.

## Timing
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset values: state=IDLE, siren=0, memo=0, remain=0, counter=0, prescaler=0.
- IDLE→DELAY: state=01 the cycle after armed & trig are sampled high.
- DELAY duration: exactly ENTRY_DLY×TICK_DIV cycles; SIREN duration: exactly SIREN_TIME×TICK_DIV cycles (no ack/disarm).
- Detection to siren latency: 1 + ENTRY_DLY×TICK_DIV cycles.
- ack or !armed takes effect on the next edge: outputs return to IDLE values one cycle later.
- ack on the same cycle as timer expiry: ack wins → IDLE.
- Reset mid-sequence: IDLE on the next edge regardless of inputs.
- trig pulse of one cycle in IDLE is enough to start the sequence; trig dropping afterwards does not cancel it.

## Configuration
- ALARM_STROBE_EN defined: in SIREN, siren toggles on every tick, starting at 1 on SIREN entry (strobe/beep pattern). It is forced to 0 on leaving SIREN.
- Not defined: siren is steady 1 for the whole of SIREN.
- memo, state, remain and all timing are identical in both builds.

## Test plan
(TICK_DIV=1, ENTRY_DLY=4, SIREN_TIME=6, macro undefined unless stated)
- Reset with trig=1, armed=1 held → state=00, siren=0, memo=0, remain=0. After reset release: DELAY next cycle, remain 3,2,1,0, then SIREN for 6 cycles, then HOLD with memo=1, siren=0.
- ack pulse at DELAY remain=2 → IDLE next cycle; siren never asserts.
- armed dropped mid-SIREN → IDLE next cycle, siren=0, memo=0.
- In HOLD, trig=1 → SIREN again with remain=5. ack while in SIREN → IDLE next cycle.
- ack coinciding with the last SIREN tick → IDLE, not HOLD. With TICK_DIV=3, DELAY lasts 12 cycles.
- ALARM_STROBE_EN defined → siren reads 1,0,1,0,1,0 across the 6 SIREN cycles, then 0 in HOLD.
